// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial add/subtract unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/rise_detect.sv
// Single-cycle pulse on each rising edge of a level input.
module rise_detect (
    input  logic clk,
    input  logic n_rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    // History resets to 0 so a level already high at reset release counts as an edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) level_q <= 1'b0;
        else        level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial unsigned add/subtract with sign-magnitude result and
// start/busy/done handshake: start rising edge launches, done pulses once.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             sign,
    output logic [WIDTH-1:0] mag,
    output logic             carry
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("addsub_serial: WIDTH must be at least 2");
    end
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("addsub_serial: WIDTH must be a multiple of DIGIT");
    end

    state_t           state, state_next;
    logic             start_edge;
    logic [WIDTH-1:0] a_sh, b_sh, acc;
    logic             op_mode;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             last_digit;
    logic [DIGIT-1:0] da, db;
    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] acc_neg;

    rise_detect u_rise (
        .clk   (clk),
        .n_rst (n_rst),
        .level (start),
        .rise  (start_edge)
    );

    assign last_digit = (cnt == CW'(N - 1));
    assign busy       = (state != IDLE);

    // One digit per cycle; subtract inverts b and relies on the preset carry for the +1.
    always_comb begin
        da       = a_sh[DIGIT-1:0];
        db       = b_sh[DIGIT-1:0] ^ {DIGIT{op_mode}};
        dsum     = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, cy};
        acc_next = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        acc_neg  = (~acc) + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_edge) state_next = RUN;
            RUN:     if (last_digit) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            op_mode <= MODE_ADD;
            cy      <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            sign    <= 1'b0;
            mag     <= '0;
            carry   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        op_mode <= mode;
                        acc     <= '0;
                        cnt     <= '0;
                        cy      <= mode;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> DIGIT;
                    b_sh <= b_sh >> DIGIT;
                    acc  <= acc_next;
                    cy   <= dsum[DIGIT];
                    cnt  <= cnt + CW'(1);
                end
                FIX: begin
                    done <= 1'b1;
                    if (op_mode == MODE_ADD) begin
                        sign  <= 1'b0;
                        mag   <= acc;
                        carry <= cy;
                    end else begin
                        // No carry out of a + ~b + 1 means a < b: report the magnitude.
                        sign  <= ~cy;
                        mag   <= cy ? acc : acc_neg;
                        carry <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: 8-bit bit-serial and 16-bit nibble-serial instances.
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start8, mode8, start16, mode16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy8, done8, sign8, carry8;
    logic [7:0]  mag8;
    logic        busy16, done16, sign16, carry16;
    logic [15:0] mag16;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .n_rst(n_rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sign(sign8), .mag(mag8), .carry(carry8)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .n_rst(n_rst), .start(start16), .mode(mode16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .sign(sign16), .mag(mag16), .carry(carry16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; launches one op on the selected instance and checks it.
    task automatic run_op(input bit wide, input logic md, input logic [15:0] va, input logic [15:0] vb,
                          input logic es, input logic [15:0] em, input logic ec,
                          input int elat, input logic [15:0] hold_mag);
        int   cyc, bcnt;
        bit   got;
        logic b_o, d_o;
        cyc = 0; bcnt = 0; got = 0;
        if (wide) begin a16 = va; b16 = vb; mode16 = md; start16 = 1'b1; end
        else      begin a8 = va[7:0]; b8 = vb[7:0]; mode8 = md; start8 = 1'b1; end
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                a8 = ~a8; b8 = ~b8; mode8 = ~mode8;
                a16 = ~a16; b16 = ~b16; mode16 = ~mode16;
            end
            if (cyc == 2) check("hold_mag", wide ? 32'(mag16) : 32'(mag8), 32'(hold_mag));
            b_o = wide ? busy16 : busy8;
            d_o = wide ? done16 : done8;
            if (d_o) begin
                got = 1;
                check("busy_at_done", 32'(b_o), 0);
            end else if (b_o) begin
                bcnt++;
            end
        end
        check("done_seen", 32'(got), 1);
        check("latency", 32'(cyc - 1), 32'(elat));
        check("busy_cycles", 32'(bcnt), 32'(elat));
        check("sign",  wide ? 32'(sign16)  : 32'(sign8),  32'(es));
        check("mag",   wide ? 32'(mag16)   : 32'(mag8),   32'(em));
        check("carry", wide ? 32'(carry16) : 32'(carry8), 32'(ec));
        start8 = 1'b0; start16 = 1'b0;
        @(negedge clk);
        check("done_pulse", wide ? 32'(done16) : 32'(done8), 0);
    endtask

    task automatic count_done8(input int cycles, output int dcnt);
        dcnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done8) dcnt++;
        end
    endtask

    initial begin
        int dcnt;
        n_rst = 1'b0; start8 = 1'b0; start16 = 1'b0; mode8 = 1'b0; mode16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_sign", 32'(sign8), 0);
        check("rst_mag", 32'(mag8), 0);
        check("rst_carry", 32'(carry8), 0);
        check("rst_mag16", 32'(mag16), 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        run_op(0, 1'b1, 200, 55,  1'b0, 145, 1'b0, 9, 0);
        run_op(0, 1'b1, 55,  200, 1'b1, 145, 1'b0, 9, 145);
        run_op(0, 1'b1, 77,  77,  1'b0, 0,   1'b0, 9, 145);
        run_op(0, 1'b1, 0,   255, 1'b1, 255, 1'b0, 9, 0);
        run_op(0, 1'b0, 255, 255, 1'b0, 254, 1'b1, 9, 255);
        run_op(0, 1'b0, 3,   4,   1'b0, 7,   1'b0, 9, 254);
        run_op(1, 1'b1, 1000,  60000, 1'b1, 59000, 1'b0, 5, 0);
        run_op(1, 1'b0, 40000, 30000, 1'b0, 4464,  1'b1, 5, 59000);

        // Level held high: one op only.
        a8 = 10; b8 = 20; mode8 = 1'b0; start8 = 1'b1;
        count_done8(30, dcnt);
        start8 = 1'b0;
        check("held_one_done", 32'(dcnt), 1);
        check("held_mag", 32'(mag8), 30);
        @(negedge clk);

        // Second rising edge while busy is dropped.
        a8 = 100; b8 = 1; mode8 = 1'b1; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        count_done8(25, dcnt);
        start8 = 1'b0;
        check("busy_edge_one_done", 32'(dcnt), 1);
        check("busy_edge_mag", 32'(mag8), 99);
        @(negedge clk);

        // Reset in the middle of an op.
        a8 = 50; b8 = 20; mode8 = 1'b1; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy8), 0);
        check("abort_mag", 32'(mag8), 0);
        check("abort_done", 32'(done8), 0);
        check("abort_mag16", 32'(mag16), 0);
        start8 = 1'b1; a8 = 3; b8 = 4; mode8 = 1'b0;
        count_done8(12, dcnt);
        check("abort_no_done", 32'(dcnt), 0);
        n_rst = 1'b1;
        run_op(0, 1'b0, 3, 4, 1'b0, 7, 1'b0, 9, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, digit-serial unsigned add/subtract unit with sign-magnitude result and a start/busy/done handshake. It is the successor of our fixed 4-bit single-cycle subtractor. It adds operand width and digit size as parameters, an add mode, a carry flag, rising-edge start detection, and fixed multi-cycle latency. It sits between the operand registers/switch inputs and the display/result registers of the arithmetic datapath.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- DIGIT, 1, bits processed per cycle. WIDTH % DIGIT must equal 0; elaboration error otherwise.

Ports:
- clk  in  1  single clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  level input; one operation is launched per rising edge of start.
- mode  in  1  0 = add (a+b), 1 = subtract (a−b). Sampled with operands.
- a  in  WIDTH  unsigned operand A.
- b  in  WIDTH  unsigned operand B.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when outputs update.
- sign  out  1  1 = result negative (subtract with a<b only).
- mag  out  WIDTH  result magnitude.
- carry  out  1  add: carry-out of MSB; subtract: always 0.

## Operation
- Reset value of all outputs is 0. The FSM resets to IDLE, and the start history register resets to 0.
- Start edge: start_edge = start & ~start_q, where start_q is start registered every cycle.
  - A start held high through reset release therefore launches one operation.
  - Holding start high launches exactly one operation.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - On start_edge, latch a, b and mode.
  - Clear the accumulator, set the digit counter to 0, and set the internal carry to mode. Mode 1 supplies the +1 of the two's complement.
  - Go to RUN.
  - start_edge in any other state is ignored and not queued.
- RUN:
  - Each cycle, add DIGIT bits of a with DIGIT bits of b, LSB digit first. In subtract mode, b is inverted.
  - Use the internal carry, write the sum digit into the accumulator, and update the carry.
  - After N = WIDTH/DIGIT digits, go to FIX.
- FIX: one cycle, then IDLE. Outputs update as follows:
  - Add: mag = accumulator, carry = final carry, sign = 0.
  - Subtract with final carry 1 (a ≥ b): sign = 0, mag = accumulator.
  - Subtract with final carry 0 (a < b): sign = 1, mag = two's-complement negation of the accumulator (WIDTH bits, modulo 2^WIDTH).
  - In subtract mode, carry = 0.
- sign, mag and carry hold their values until the next FIX or reset. They are not cleared on a new start.
- Changes on a, b or mode after latching have no effect on the running operation.

## Timing
- Let edge E be the clock edge at which start_edge is sampled high in IDLE.
- busy is 1 from E+1 through the end of FIX. It is 0 again after edge E+N+1.
- The RUN digits are processed at edges E+1 … E+N. FIX occurs at edge E+N+1: the outputs and done become valid after E+N+1, and done is high for exactly one cycle.
- Total latency is N+1 edges. With the defaults (N=8), done appears 9 cycles after the start edge.
- The earliest accepted back-to-back start is a start_edge sampled at the edge after done. start must be low for at least one sampled cycle between operations.
- Reset asserted mid-operation:
  - Immediate abort: outputs go to 0, the FSM goes to IDLE, and no done is produced.
  - Latched operands are discarded.

## Structure
- Package addsub_pkg:
  - state enum {IDLE, RUN, FIX};
  - mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- Sub-module rise_detect: one flop plus AND, with clk and n_rst. It produces start_edge and is reusable by other blocks that currently rely on level start.
- Top level holds:
  - the FSM;
  - a digit counter of width $clog2(N+1);
  - operand shift registers;
  - the accumulator;
  - a one-bit carry register;
  - the FIX negation logic.

## Test plan
- WIDTH=8, DIGIT=1, sub a=200, b=55 → done after 9 cycles; sign=0, mag=145, carry=0, busy high for 9 cycles.
- Sub a=55, b=200 → sign=1, mag=145. Sub a=b=77 → sign=0, mag=0. Sub a=0, b=255 → sign=1, mag=255.
- Add a=255, b=255 → mag=254, carry=1, sign=0. Add a=3, b=4 → mag=7, carry=0.
- start held high for 30 cycles → exactly one done. A second rising edge of start while busy → ignored, and only one done pulse.
- Reset pulsed at cycle 4 of a running op → outputs 0, no done. A start high at reset release → one op, correct result.
- WIDTH=16, DIGIT=4, sub a=1000, b=60000 → done 5 cycles after the edge; sign=1, mag=59000.
